// File: rtl/ext_sram_byte_arbiter.sv
// ext_sram_byte_arbiter
//
// Shares one 8-bit external SRAM port between the core's instruction-fetch
// and data request interfaces. Two 32-bit req/gnt/rvalid requesters are
// arbitrated round-robin; the winning word access is split into byte beats
// on the SRAM pins (little-endian, beat k <-> bits [8k+7:8k]).
//
// Handshake (both requester ports):
//   A requester raises req with its fields stable and holds them until it
//   sees gnt. gnt is combinational, only offered in IDLE, and at most one
//   port is granted per cycle. The fields are latched in the gnt cycle.
//   Exactly one cycle later or more, the owning port sees a single-cycle
//   rvalid pulse; rdata/err are valid with it and then hold their value
//   until that port's next rvalid. Only one access is outstanding at a time.
//
// Ports:
//   clk_i, rst_i             clock, synchronous active-high reset
//   instr_req_i/gnt_o        instruction read request / accept
//   instr_addr_i             instruction byte address (bits [1:0] ignored)
//   instr_rvalid_o/rdata_o/err_o  instruction response
//   data_req_i/gnt_o         data request / accept
//   data_we_i/be_i/addr_i/wdata_i data request fields
//   data_rvalid_o/rdata_o/err_o   data response
//   sram_addr_o/read_o/write_o/wdata_o/rdata_i  external 8-bit SRAM pins
//
// Parameters:
//   ADDR_W  external SRAM byte-address width (must be < 32)
//   RD_LAT  cycles from a sram_read_o strobe to valid sram_rdata_i (1..3)

module ext_sram_byte_arbiter #(
  parameter int ADDR_W = 16,
  parameter int RD_LAT = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              instr_req_i,
  output logic              instr_gnt_o,
  output logic              instr_rvalid_o,
  input  logic [31:0]       instr_addr_i,
  output logic [31:0]       instr_rdata_o,
  output logic              instr_err_o,
  input  logic              data_req_i,
  output logic              data_gnt_o,
  output logic              data_rvalid_o,
  input  logic              data_we_i,
  input  logic [3:0]        data_be_i,
  input  logic [31:0]       data_addr_i,
  input  logic [31:0]       data_wdata_i,
  output logic [31:0]       data_rdata_o,
  output logic              data_err_o,
  input  logic [7:0]        sram_rdata_i,
  output logic [7:0]        sram_wdata_o,
  output logic [ADDR_W-1:0] sram_addr_o,
  output logic              sram_read_o,
  output logic              sram_write_o
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_BEAT = 2'd1,
    WR_BEAT = 2'd2,
    RESP    = 2'd3
  } state_t;

  state_t state_q, state_d;

  // Round-robin pointer: 1 = data port wins a tie, 0 = instruction port.
  logic ptr_data_q;
  // Port owning the current access: 1 = data, 0 = instruction.
  logic owner_q;

  logic [ADDR_W-3:0] word_q;     // word address of the current access
  logic [3:0]        be_q;       // write beats still to issue
  logic [31:0]       wdata_q;
  logic              err_q;
  logic [31:0]       rd_word_q;  // read word being assembled

  // Reads are pipelined: the issue counter strobes four beats back to back
  // while the capture counter collects bytes as they return RD_LAT later.
  logic [2:0]        iss_cnt_q;
  logic [1:0]        cap_cnt_q;
  logic [RD_LAT-1:0] rd_pipe_q;  // one bit per strobe in flight
  logic              cap_fire;

  // Response values held between rvalid pulses of each port.
  logic [31:0] instr_rdata_q, data_rdata_q;
  logic        instr_err_q, data_err_q;

  // Grant selection and the fields of the winning port.
  logic        grant_instr, grant_data, grant_any;
  logic        g_we;
  logic [3:0]  g_be;
  logic [31:0] g_addr;
  logic [31:0] g_wdata;
  logic        g_err;
  logic        unused_addr_bits;

  // Write beat selection: lowest remaining enabled byte lane.
  logic [1:0] wr_k;
  logic [3:0] wr_clear;

  // Grants are suppressed while reset is asserted so every output reads 0.
  assign grant_data  = (state_q == IDLE) && !rst_i && data_req_i &&
                       (!instr_req_i || ptr_data_q);
  assign grant_instr = (state_q == IDLE) && !rst_i && instr_req_i &&
                       (!data_req_i || !ptr_data_q);
  assign grant_any   = grant_data || grant_instr;

  assign instr_gnt_o = grant_instr;
  assign data_gnt_o  = grant_data;

  assign g_we    = grant_data ? data_we_i    : 1'b0;
  assign g_be    = grant_data ? data_be_i    : 4'hF;
  assign g_addr  = grant_data ? data_addr_i  : instr_addr_i;
  assign g_wdata = grant_data ? data_wdata_i : 32'h0;
  // Anything above the SRAM address space is answered with an error.
  assign g_err   = (g_addr[31:ADDR_W] != '0);
  // The byte offset within the word plays no part in the access.
  assign unused_addr_bits = ^g_addr[1:0];

  always_comb begin
    wr_k = 2'd3;
    if (be_q[0])      wr_k = 2'd0;
    else if (be_q[1]) wr_k = 2'd1;
    else if (be_q[2]) wr_k = 2'd2;
  end

  assign wr_clear = 4'b0001 << wr_k;
  assign cap_fire = (state_q == RD_BEAT) && rd_pipe_q[RD_LAT-1];

  // Next state and SRAM pin drive.
  always_comb begin
    state_d      = state_q;
    sram_read_o  = 1'b0;
    sram_write_o = 1'b0;
    sram_addr_o  = '0;
    sram_wdata_o = 8'h00;
    case (state_q)
      IDLE: begin
        if (grant_any) begin
          if (g_err)              state_d = RESP;
          else if (!g_we)         state_d = RD_BEAT;
          else if (g_be == 4'h0)  state_d = RESP;
          else                    state_d = WR_BEAT;
        end
      end
      RD_BEAT: begin
        if (iss_cnt_q < 3'd4) begin
          sram_read_o = 1'b1;
          sram_addr_o = {word_q, iss_cnt_q[1:0]};
        end
        if (cap_fire && (cap_cnt_q == 2'd3)) state_d = RESP;
      end
      WR_BEAT: begin
        sram_write_o = 1'b1;
        sram_addr_o  = {word_q, wr_k};
        sram_wdata_o = wdata_q[{wr_k, 3'b000} +: 8];
        if ((be_q & ~wr_clear) == 4'h0) state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q       <= IDLE;
      ptr_data_q    <= 1'b1;
      owner_q       <= 1'b0;
      word_q        <= '0;
      be_q          <= 4'h0;
      wdata_q       <= 32'h0;
      err_q         <= 1'b0;
      rd_word_q     <= 32'h0;
      iss_cnt_q     <= 3'd0;
      cap_cnt_q     <= 2'd0;
      rd_pipe_q     <= '0;
      instr_rdata_q <= 32'h0;
      instr_err_q   <= 1'b0;
      data_rdata_q  <= 32'h0;
      data_err_q    <= 1'b0;
    end else begin
      state_q <= state_d;

      rd_pipe_q[0] <= sram_read_o;
      for (int i = 1; i < RD_LAT; i++) begin
        rd_pipe_q[i] <= rd_pipe_q[i-1];
      end

      if (grant_any) begin
        owner_q    <= grant_data;
        ptr_data_q <= grant_instr;
        word_q     <= g_addr[ADDR_W-1:2];
        be_q       <= g_be;
        wdata_q    <= g_wdata;
        err_q      <= g_err;
        rd_word_q  <= 32'h0;
        iss_cnt_q  <= 3'd0;
        cap_cnt_q  <= 2'd0;
      end

      if ((state_q == RD_BEAT) && (iss_cnt_q < 3'd4)) begin
        iss_cnt_q <= iss_cnt_q + 3'd1;
      end

      if (cap_fire) begin
        rd_word_q[{cap_cnt_q, 3'b000} +: 8] <= sram_rdata_i;
        cap_cnt_q <= cap_cnt_q + 2'd1;
      end

      if (state_q == WR_BEAT) begin
        be_q <= be_q & ~wr_clear;
      end

      // Keep the response visible after the rvalid pulse.
      if (state_q == RESP) begin
        if (owner_q) begin
          data_rdata_q <= rd_word_q;
          data_err_q   <= err_q;
        end else begin
          instr_rdata_q <= rd_word_q;
          instr_err_q   <= err_q;
        end
      end
    end
  end

  assign instr_rvalid_o = (state_q == RESP) && !owner_q;
  assign data_rvalid_o  = (state_q == RESP) && owner_q;

  assign instr_rdata_o = instr_rvalid_o ? rd_word_q : instr_rdata_q;
  assign instr_err_o   = instr_rvalid_o ? err_q     : instr_err_q;
  assign data_rdata_o  = data_rvalid_o  ? rd_word_q : data_rdata_q;
  assign data_err_o    = data_rvalid_o  ? err_q     : data_err_q;

endmodule

// File: tb/tb_ext_sram_byte_arbiter.sv
// Testbench for ext_sram_byte_arbiter: one instance with RD_LAT=1 and a
// second with RD_LAT=3, each wired to a behavioural byte-wide SRAM.

module tb_ext_sram_byte_arbiter;

  localparam int ADDR_W = 16;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;
  int   cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT 1 (RD_LAT = 1) ----------------
  logic        instr_req, instr_gnt, instr_rvalid, instr_err;
  logic [31:0] instr_addr, instr_rdata;
  logic        data_req, data_gnt, data_rvalid, data_we, data_err;
  logic [3:0]  data_be;
  logic [31:0] data_addr, data_wdata, data_rdata;
  logic [7:0]  s1_rdata, s1_wdata;
  logic [15:0] s1_addr;
  logic        s1_read, s1_write;

  ext_sram_byte_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(1)) dut1 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req), .instr_gnt_o(instr_gnt), .instr_rvalid_o(instr_rvalid),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata), .instr_err_o(instr_err),
    .data_req_i(data_req), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
    .data_we_i(data_we), .data_be_i(data_be), .data_addr_i(data_addr),
    .data_wdata_i(data_wdata), .data_rdata_o(data_rdata), .data_err_o(data_err),
    .sram_rdata_i(s1_rdata), .sram_wdata_o(s1_wdata), .sram_addr_o(s1_addr),
    .sram_read_o(s1_read), .sram_write_o(s1_write)
  );

  // ---------------- DUT 3 (RD_LAT = 3), instruction port only ----------------
  logic        instr_req3, instr_gnt3, instr_rvalid3, instr_err3;
  logic [31:0] instr_rdata3;
  logic        data_gnt3, data_rvalid3, data_err3;
  logic [31:0] data_rdata3;
  logic        zero1;
  logic [3:0]  zero4;
  logic [31:0] zero32;
  logic [7:0]  s3_rdata, s3_wdata;
  logic [15:0] s3_addr;
  logic        s3_read, s3_write;

  ext_sram_byte_arbiter #(.ADDR_W(ADDR_W), .RD_LAT(3)) dut3 (
    .clk_i(clk), .rst_i(rst),
    .instr_req_i(instr_req3), .instr_gnt_o(instr_gnt3), .instr_rvalid_o(instr_rvalid3),
    .instr_addr_i(instr_addr), .instr_rdata_o(instr_rdata3), .instr_err_o(instr_err3),
    .data_req_i(zero1), .data_gnt_o(data_gnt3), .data_rvalid_o(data_rvalid3),
    .data_we_i(zero1), .data_be_i(zero4), .data_addr_i(zero32),
    .data_wdata_i(zero32), .data_rdata_o(data_rdata3), .data_err_o(data_err3),
    .sram_rdata_i(s3_rdata), .sram_wdata_o(s3_wdata), .sram_addr_o(s3_addr),
    .sram_read_o(s3_read), .sram_write_o(s3_write)
  );

  // ---------------- SRAM models ----------------
  logic [7:0] mem1 [0:65535];
  logic [7:0] mem3 [0:65535];
  logic [7:0] pipe1;
  logic [7:0] pipe3 [0:2];

  always @(posedge clk) begin
    if (s1_write) mem1[s1_addr] <= s1_wdata;
    pipe1 <= s1_read ? mem1[s1_addr] : 8'h00;
    if (s3_write) mem3[s3_addr] <= s3_wdata;
    pipe3[0] <= s3_read ? mem3[s3_addr] : 8'h00;
    pipe3[1] <= pipe3[0];
    pipe3[2] <= pipe3[1];
  end
  assign s1_rdata = pipe1;
  assign s3_rdata = pipe3[2];

  // ---------------- scoreboard ----------------
  typedef struct packed {
    logic [1:0]  dut;
    logic        port;   // 1 = data
    logic [31:0] rdata;
    logic        err;
    logic [31:0] cyc;
  } exp_t;
  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } stb_t;

  exp_t exp_q[$];
  stb_t stb_q[$];
  int   n_vec = 0;
  int   n_err = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
    n_vec++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  // Response monitor and SRAM pin monitor for DUT 1.
  always @(negedge clk) begin
    exp_t       e;
    int         nv;
    logic [1:0] a_dut;
    logic       a_port;
    logic [31:0] a_rdata;
    logic       a_err;
    stb_t       s, a_s;
    nv = int'(instr_rvalid === 1'b1) + int'(data_rvalid === 1'b1) +
         int'(instr_rvalid3 === 1'b1) + int'(data_rvalid3 === 1'b1);
    if (nv > 1) begin
      check("single_rvalid", nv, 1);
    end else if (nv == 1) begin
      a_dut   = (instr_rvalid3 || data_rvalid3) ? 2'd3 : 2'd1;
      a_port  = data_rvalid || data_rvalid3;
      a_rdata = instr_rvalid ? instr_rdata : data_rvalid ? data_rdata :
                instr_rvalid3 ? instr_rdata3 : data_rdata3;
      a_err   = instr_rvalid ? instr_err : data_rvalid ? data_err :
                instr_rvalid3 ? instr_err3 : data_err3;
      if (exp_q.size() == 0) begin
        check("unexpected_rvalid", {a_dut, a_port}, 0);
      end else begin
        e = exp_q.pop_front();
        check("rsp_port", {a_dut, a_port}, {e.dut, e.port});
        check("rsp_rdata", a_rdata, e.rdata);
        check("rsp_err", a_err, e.err);
        check("rsp_cycle", cyc, e.cyc);
      end
    end

    if (s1_read === 1'b1 && s1_write === 1'b1) begin
      check("both_strobes", 1, 0);
    end else if (s1_read === 1'b1 || s1_write === 1'b1) begin
      a_s = '{we: s1_write, addr: s1_addr, wdata: (s1_write ? s1_wdata : 8'h00)};
      if (stb_q.size() == 0) begin
        check("unexpected_strobe", a_s, 0);
      end else begin
        s = stb_q.pop_front();
        check("strobe", a_s, s);
      end
    end else if (!rst) begin
      check("idle_pins", {s1_addr, s1_wdata}, 0);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_expect(input int d, input logic port, input logic we,
                             input logic [3:0] be, input logic [31:0] addr,
                             input logic [31:0] wdata, input logic [31:0] rdata,
                             input logic err, input int t);
    int         lat;
    logic [15:0] base;
    base = addr[15:0] & 16'hFFFC;
    if (err)     lat = 1;
    else if (we) lat = 1 + $countones(be);
    else         lat = 5 + ((d == 3) ? 3 : 1);
    exp_q.push_back('{dut: d[1:0], port: port, rdata: rdata, err: err, cyc: t + lat});
    if (d == 1 && !err) begin
      for (int k = 0; k < 4; k++) begin
        if (!we)
          stb_q.push_back('{we: 1'b0, addr: base + 16'(k), wdata: 8'h00});
        else if (be[k])
          stb_q.push_back('{we: 1'b1, addr: base + 16'(k), wdata: wdata[8*k +: 8]});
      end
    end
  endtask

  task automatic issue(input int d, input logic port, input logic we,
                       input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [31:0] rdata,
                       input logic err);
    int   waited;
    logic g;
    @(negedge clk);
    if (d == 3) begin
      instr_addr = addr; instr_req3 = 1'b1;
    end else if (port) begin
      data_req = 1'b1; data_we = we; data_be = be; data_addr = addr; data_wdata = wdata;
    end else begin
      instr_req = 1'b1; instr_addr = addr;
    end
    #1;
    waited = 0;
    g = (d == 3) ? instr_gnt3 : port ? data_gnt : instr_gnt;
    while (!g && waited < 50) begin
      @(negedge clk); #1;
      waited++;
      g = (d == 3) ? instr_gnt3 : port ? data_gnt : instr_gnt;
    end
    check("gnt_seen", g, 1);
    push_expect(d, port, we, be, addr, wdata, rdata, err, cyc);
    @(negedge clk);
    instr_req = 1'b0; data_req = 1'b0; instr_req3 = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || stb_q.size() != 0) && n < 100) begin
      @(negedge clk); #2;
      n++;
    end
    check("drain", exp_q.size() + stb_q.size(), 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  logic [3:0] rr_order;
  logic       gi, gd;
  int         t, waited;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem1[i] = 8'h00;
      mem3[i] = 8'h00;
    end
    mem1[16'h104] = 8'h11; mem1[16'h105] = 8'h22; mem1[16'h106] = 8'h33; mem1[16'h107] = 8'h44;
    mem1[16'h200] = 8'h01; mem1[16'h201] = 8'h02; mem1[16'h202] = 8'h03; mem1[16'h203] = 8'h04;
    mem3[16'h104] = 8'h11; mem3[16'h105] = 8'h22; mem3[16'h106] = 8'h33; mem3[16'h107] = 8'h44;
    zero1 = 1'b0; zero4 = 4'h0; zero32 = 32'h0;
    instr_req = 1'b0; instr_addr = 32'h0; instr_req3 = 1'b0;
    data_req = 1'b0; data_we = 1'b0; data_be = 4'h0; data_addr = 32'h0; data_wdata = 32'h0;
    rst = 1'b1;

    // Reset state: every output 0 even with requests pending.
    repeat (2) @(negedge clk);
    instr_req = 1'b1; data_req = 1'b1;
    #1;
    check("reset_state", {instr_gnt, instr_rvalid, instr_rdata, instr_err, data_gnt, data_rvalid,
                          data_rdata, data_err, s1_wdata, s1_addr, s1_read, s1_write}, 0);
    check("reset_state3", {instr_gnt3, instr_rvalid3, instr_rdata3, instr_err3, s3_read, s3_write}, 0);
    instr_req = 1'b0; data_req = 1'b0;

    // Contention from reset: data, instr, data, instr.
    @(negedge clk);
    rst = 1'b0;
    instr_req = 1'b1; instr_addr = 32'h0000_0104;
    data_req = 1'b1; data_we = 1'b0; data_be = 4'hF; data_addr = 32'h0000_0200;
    rr_order = 4'b0101;
    for (int g = 0; g < 4; g++) begin
      waited = 0;
      #1; gi = instr_gnt; gd = data_gnt;
      while (!(gi || gd) && waited < 50) begin
        @(negedge clk); #1;
        gi = instr_gnt; gd = data_gnt;
        waited++;
      end
      check("no_dual_gnt", gi & gd, 0);
      check("rr_order", {gi, gd}, {~rr_order[g], rr_order[g]});
      if (gd) push_expect(1, 1'b1, 1'b0, 4'hF, 32'h200, 32'h0, 32'h0403_0201, 1'b0, cyc);
      else    push_expect(1, 1'b0, 1'b0, 4'hF, 32'h104, 32'h0, 32'h4433_2211, 1'b0, cyc);
      @(negedge clk);
    end
    instr_req = 1'b0; data_req = 1'b0;
    wait_drain();

    // Single read, sparse write and its readback.
    issue(1, 1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 32'h4433_2211, 1'b0);
    wait_drain();
    issue(1, 1'b1, 1'b1, 4'b1010, 32'h0000_0020, 32'hAABB_CCDD, 32'h0, 1'b0);
    wait_drain();
    issue(1, 1'b1, 1'b0, 4'hF, 32'h0000_0020, 32'h0, 32'hAA00_CC00, 1'b0);
    wait_drain();

    // Full write, then an instruction read with a misaligned address.
    issue(1, 1'b1, 1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678, 32'h0, 1'b0);
    wait_drain();
    issue(1, 1'b0, 1'b0, 4'hF, 32'h0000_0043, 32'h0, 32'h1234_5678, 1'b0);
    wait_drain();

    // Out of range read and empty write.
    issue(1, 1'b1, 1'b0, 4'hF, 32'h0001_0000, 32'h0, 32'h0, 1'b1);
    wait_drain();
    check("hold_instr", {instr_rdata, instr_err}, {32'h1234_5678, 1'b0});
    check("hold_data", {data_rdata, data_err}, {32'h0, 1'b1});
    issue(1, 1'b1, 1'b1, 4'h0, 32'h0000_0030, 32'hFFFF_FFFF, 32'h0, 1'b0);
    wait_drain();
    check("hold_data_after_write", {data_rdata, data_err}, {32'h0, 1'b0});

    // Reset in the middle of a read, after beat 1.
    @(negedge clk);
    instr_req = 1'b1; instr_addr = 32'h0000_0104;
    #1;
    check("rst_read_gnt", instr_gnt, 1);
    stb_q.push_back('{we: 1'b0, addr: 16'h104, wdata: 8'h00});
    stb_q.push_back('{we: 1'b0, addr: 16'h105, wdata: 8'h00});
    @(negedge clk);
    instr_req = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    check("after_reset_outputs", {instr_gnt, instr_rvalid, instr_rdata, instr_err, data_gnt,
                                  data_rvalid, data_rdata, data_err, s1_wdata, s1_addr,
                                  s1_read, s1_write}, 0);
    rst = 1'b0;
    repeat (10) @(negedge clk);
    check("no_stale_strobes", stb_q.size(), 0);
    issue(1, 1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 32'h4433_2211, 1'b0);
    wait_drain();

    // RD_LAT = 3 instance.
    issue(3, 1'b0, 1'b0, 4'hF, 32'h0000_0104, 32'h0, 32'h4433_2211, 1'b0);
    wait_drain();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1, "timeout");
  end

endmodule
